csi2_packet_decoder: RTL and testbench

Byte-clock stage directly downstream of the 2-lane MIPI D-PHY deserialiser. It consumes lane-aligned HS bytes (lane0/lane1 per cycle), parses CSI-2 packet headers, checks ECC, and emits frame/line strobes plus a RAW8 pixel stream with a linear frame-buffer address. Its output feeds the pixel writer / frame buffer.

---
 rtl/csi2_pkg.sv | 38 +++
 rtl/csi2_packet_decoder_if.sv | 34 +++
 rtl/csi2_ecc_check.sv | 17 +
 rtl/csi2_packet_decoder.sv | 150 +++++++++++++++
 tb/tb_csi2_packet_decoder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - shared CSI-2 data types, decoder states and header ECC
//
// Purpose: CSI-2 data-type codes, the packet decoder state encoding and the
// 24-bit header ECC function. Shared by the decoder and the deserialiser
// debug path.
package csi2_pkg;

  typedef enum logic [5:0] {
    DT_FS    = 6'h00,
    DT_FE    = 6'h01,
    DT_ED    = 6'h12,
    DT_RAW8  = 6'h2A,
    DT_RAW10 = 6'h2B
  } dt_e;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    WAIT_EOT
  } state_t;

  // Each parity bit is the XOR of the header bits selected by its mask
  // (bit i of the mask selects header bit D[i]). Bits [7:6] are always 0.
  localparam logic [23:0] ECC_P0_MASK = 24'hF12CB7;
  localparam logic [23:0] ECC_P1_MASK = 24'hF2555B;
  localparam logic [23:0] ECC_P2_MASK = 24'h749A6D;
  localparam logic [23:0] ECC_P3_MASK = 24'hB8E38E;
  localparam logic [23:0] ECC_P4_MASK = 24'hDF03F0;
  localparam logic [23:0] ECC_P5_MASK = 24'hEFFC00;

  function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
    return {2'b00,
            ^(d & ECC_P5_MASK), ^(d & ECC_P4_MASK), ^(d & ECC_P3_MASK),
            ^(d & ECC_P2_MASK), ^(d & ECC_P1_MASK), ^(d & ECC_P0_MASK)};
  endfunction

endpackage

// File: rtl/csi2_packet_decoder_if.sv
// rtl/csi2_packet_decoder_if.sv - lane byte input and decoded output bundle
//
// Purpose: groups the deserialiser-side byte lanes and the decoded
// strobes/pixel stream of csi2_packet_decoder.
// Signals: lane0_byte/lane1_byte/byte_valid (PHY -> decoder);
//          frame_start/frame_end/line_start/ecc_err/trunc_err strobes,
//          pix_data/pix_valid/pix_addr pixel stream, line_cnt (decoder -> sink).
// Modports: slave = decoder side, master = PHY/sink side.
interface csi2_packet_decoder_if;
  logic [7:0]  lane0_byte;
  logic [7:0]  lane1_byte;
  logic        byte_valid;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic [15:0] pix_data;
  logic [1:0]  pix_valid;
  logic [24:0] pix_addr;
  logic [15:0] line_cnt;
  logic        ecc_err;
  logic        trunc_err;

  modport slave (
    input  lane0_byte, lane1_byte, byte_valid,
    output frame_start, frame_end, line_start, pix_data, pix_valid,
           pix_addr, line_cnt, ecc_err, trunc_err
  );

  modport master (
    output lane0_byte, lane1_byte, byte_valid,
    input  frame_start, frame_end, line_start, pix_data, pix_valid,
           pix_addr, line_cnt, ecc_err, trunc_err
  );
endinterface

// File: rtl/csi2_ecc_check.sv
// rtl/csi2_ecc_check.sv - combinational CSI-2 packet header ECC match
//
// Purpose: compares the received ECC byte against the ECC computed over
// the 24-bit header {WC_hi, WC_lo, DI}.
// Ports: hdr (24-bit header, DI in [7:0]), ecc (received ECC byte),
//        match (1 when they agree).
module csi2_ecc_check
  import csi2_pkg::*;
(
  input  logic [23:0] hdr,
  input  logic [7:0]  ecc,
  output logic        match
);

  assign match = (csi2_ecc(hdr) == ecc);

endmodule

// File: rtl/csi2_packet_decoder.sv
// rtl/csi2_packet_decoder.sv - CSI-2 2-lane header parser and RAW8 pixel emitter
//
// Purpose: parses CSI-2 packet headers from lane-aligned HS bytes, checks
// header ECC, emits frame/line strobes and a RAW8 pixel stream with a
// linear frame-buffer address.
// Ports: byte_clk (only clock), reset_n (async active-low),
//        bus (csi2_packet_decoder_if.slave: lane bytes in, strobes/pixels out).
module csi2_packet_decoder
  import csi2_pkg::*;
#(
  parameter logic [1:0]  VC       = 2'd0,
  parameter logic [5:0]  DT_PIXEL = DT_RAW8,
  parameter logic [15:0] MAX_WC   = 16'd4096
) (
  input  logic                 byte_clk,
  input  logic                 reset_n,
  csi2_packet_decoder_if.slave bus
);

  state_t      state;
  logic        seen_low;   // byte_valid observed low since reset
  logic [15:0] hdr;        // {WC_lo, DI} from header cycle A
  logic [15:0] remain;     // payload bytes left in the current line
  logic [24:0] addr;       // address of the next pixel to emit

  logic        frame_start_q, frame_end_q, line_start_q, ecc_err_q, trunc_err_q;
  logic [15:0] pix_data_q;
  logic [1:0]  pix_valid_q;
  logic [24:0] pix_addr_q;
  logic [15:0] line_cnt_q;

  logic [5:0]  dt;
  logic [1:0]  vc_id;
  logic [15:0] wc;
  logic        hdr_ok;
  logic        two_left;
  logic [1:0]  step;

  assign dt       = hdr[5:0];
  assign vc_id    = hdr[7:6];
  assign wc       = {bus.lane0_byte, hdr[15:8]};
  assign two_left = (remain >= 16'd2);
  assign step     = two_left ? 2'd2 : 2'd1;

  // Header cycle B presents {lane1=ECC, lane0=WC_hi}.
  csi2_ecc_check u_ecc_check (
    .hdr   ({bus.lane0_byte, hdr}),
    .ecc   (bus.lane1_byte),
    .match (hdr_ok)
  );

  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      seen_low      <= 1'b0;
      hdr           <= '0;
      remain        <= '0;
      addr          <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_start_q  <= 1'b0;
      ecc_err_q     <= 1'b0;
      trunc_err_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= '0;
      pix_addr_q    <= '0;
      line_cnt_q    <= '0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_start_q  <= 1'b0;
      ecc_err_q     <= 1'b0;
      trunc_err_q   <= 1'b0;
      pix_valid_q   <= 2'b00;

      // A reset inside a burst must not resync onto payload bytes, so a
      // header is only accepted once the link has been seen idle.
      if (!bus.byte_valid) seen_low <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.byte_valid && seen_low) begin
            hdr   <= {bus.lane1_byte, bus.lane0_byte};
            state <= HDR;
          end
        end

        HDR: begin
          if (!bus.byte_valid) begin
            trunc_err_q <= 1'b1;
            state       <= IDLE;
          end else begin
            state <= WAIT_EOT;
            if (!hdr_ok) begin
              ecc_err_q <= 1'b1;
            end else if (vc_id == VC) begin
              if (dt == DT_FS) begin
                frame_start_q <= 1'b1;
                addr          <= '0;
                pix_addr_q    <= '0;
                line_cnt_q    <= '0;
              end else if (dt == DT_FE) begin
                frame_end_q <= 1'b1;
              end else if (dt == DT_PIXEL && wc != 16'd0 && wc <= MAX_WC) begin
                line_start_q <= 1'b1;
                remain       <= wc;
                state        <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (!bus.byte_valid) begin
            // Partial line: address keeps its advance, line is not counted.
            trunc_err_q <= 1'b1;
            state       <= IDLE;
          end else begin
            pix_data_q  <= {bus.lane1_byte, bus.lane0_byte};
            pix_valid_q <= two_left ? 2'b11 : 2'b01;
            pix_addr_q  <= addr;
            addr        <= addr + {23'd0, step};
            remain      <= remain - {14'd0, step};
            if (remain <= 16'd2) begin
              line_cnt_q <= line_cnt_q + 16'd1;
              state      <= WAIT_EOT;   // CRC and trailer bytes are ignored
            end
          end
        end

        WAIT_EOT: begin
          if (!bus.byte_valid) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.line_start  = line_start_q;
  assign bus.ecc_err     = ecc_err_q;
  assign bus.trunc_err   = trunc_err_q;
  assign bus.pix_data    = pix_data_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_addr    = pix_addr_q;
  assign bus.line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb/tb_csi2_packet_decoder.sv - self-checking bench for csi2_packet_decoder
module tb_csi2_packet_decoder;

  logic byte_clk;
  logic reset_n;
  csi2_packet_decoder_if bus();

  csi2_packet_decoder #(
    .VC       (2'd0),
    .DT_PIXEL (6'h2A),
    .MAX_WC   (16'd4096)
  ) dut (
    .byte_clk (byte_clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial byte_clk = 1'b0;
  always #5 byte_clk = ~byte_clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [24:0] exp_addr  = '0;
  logic [15:0] exp_lines = '0;

  // Syndrome column of each header bit D0..D23 (bits P5..P0).
  localparam logic [5:0] ECC_COL [0:23] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ECC_COL[i];
    return {2'b00, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic fs, input logic fe,
                         input logic ls, input logic ee, input logic tr,
                         input logic [1:0] pv, input logic [15:0] pd,
                         input logic [24:0] pa);
    chk({tag, ".frame_start"}, bus.frame_start, fs);
    chk({tag, ".frame_end"},   bus.frame_end,   fe);
    chk({tag, ".line_start"},  bus.line_start,  ls);
    chk({tag, ".ecc_err"},     bus.ecc_err,     ee);
    chk({tag, ".trunc_err"},   bus.trunc_err,   tr);
    chk({tag, ".pix_valid"},   bus.pix_valid,   pv);
    chk({tag, ".line_cnt"},    bus.line_cnt,    exp_lines);
    if (pv != 2'b00) begin
      chk({tag, ".pix_lo"},   bus.pix_data[7:0], pd[7:0]);
      chk({tag, ".pix_addr"}, bus.pix_addr,      pa);
      if (pv == 2'b11) chk({tag, ".pix_hi"}, bus.pix_data[15:8], pd[15:8]);
    end
  endtask

  task automatic step(input logic bv, input logic [7:0] l0, input logic [7:0] l1);
    @(negedge byte_clk);
    bus.byte_valid = bv;
    bus.lane0_byte = l0;
    bus.lane1_byte = l1;
    @(posedge byte_clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    chk_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 25'h0);
  endtask

  // Sends one packet (header, payload, CRC) and checks every output cycle.
  // cut >= 1 drops byte_valid at that pair index; pat >= 0 gives payload
  // bytes pat, pat+1, ... otherwise random.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc,
                          input bit flip, input int cut, input int pat);
    logic [7:0]  b[$];
    logic [7:0]  ecc;
    logic [24:0] base;
    logic [1:0]  pv;
    int plen, npairs, ncyc, j, sh;
    bit ok, is_fs, is_fe, is_line, tr;

    ecc = ref_ecc({wc, di});
    if (flip) begin
      sh  = $urandom_range(0, 7);
      ecc = ecc ^ (8'd1 << sh);
    end
    b = {di, wc[7:0], wc[15:8], ecc};
    if (di[5:0] >= 6'h10) begin
      plen = (wc > 16'd64 && wc != 16'd4096) ? 64 : int'(wc);
      for (int p = 0; p < plen; p++)
        b.push_back((pat < 0) ? 8'($urandom) : 8'(pat + p));
      b.push_back(8'($urandom));
      b.push_back(8'($urandom));
    end
    if (b.size() % 2 != 0) b.push_back(8'h00);
    npairs = b.size() / 2;

    ok      = !flip && (di[7:6] == 2'd0);
    is_fs   = ok && di[5:0] == 6'h00;
    is_fe   = ok && di[5:0] == 6'h01;
    is_line = ok && di[5:0] == 6'h2A && wc != 16'd0 && wc <= 16'd4096;
    ncyc    = is_line ? (int'(wc) + 1) / 2 : 0;
    base    = exp_addr;

    for (int k = 0; k < npairs; k++) begin
      if (k == cut) break;
      step(1'b1, b[2*k], b[2*k+1]);
      if (k == 1) begin
        if (is_fs) begin
          exp_addr  = '0;
          exp_lines = '0;
        end
        chk_all("hdr", is_fs, is_fe, is_line, flip, 1'b0, 2'b00, 16'h0, 25'h0);
        if (is_fs) chk("fs.pix_addr", bus.pix_addr, 25'h0);
      end else if (k >= 2 && k - 2 < ncyc) begin
        j  = k - 2;
        pv = (int'(wc) - 2 * j >= 2) ? 2'b11 : 2'b01;
        if (j == ncyc - 1) begin
          exp_lines = exp_lines + 16'd1;
          exp_addr  = base + 25'(wc);
        end
        chk_all("pix", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pv,
                {b[5+2*j], b[4+2*j]}, base + 25'(2 * j));
      end else begin
        quiet("body");
      end
    end

    step(1'b0, 8'($urandom), 8'($urandom));
    if (cut >= 1 && cut < npairs) begin
      tr = (cut == 1) || (is_line && cut >= 2 && cut < 2 + ncyc);
      if (is_line && cut >= 2 && cut < 2 + ncyc) exp_addr = base + 25'(2 * (cut - 2));
      chk_all("cut", 1'b0, 1'b0, 1'b0, 1'b0, tr, 2'b00, 16'h0, 25'h0);
    end else begin
      quiet("eot");
    end
    repeat ($urandom_range(0, 2)) begin
      step(1'b0, 8'h00, 8'h00);
      quiet("gap");
    end
  endtask

  logic [7:0] dt_tab [0:7];
  logic [7:0] rdi;
  logic [15:0] rwc;
  int rcut;

  initial begin
    dt_tab = '{8'h00, 8'h01, 8'h2A, 8'h2A, 8'h2A, 8'h2B, 8'h12, 8'h07};

    reset_n        = 1'b0;
    bus.byte_valid = 1'b0;
    bus.lane0_byte = 8'h00;
    bus.lane1_byte = 8'h00;
    repeat (3) @(posedge byte_clk);
    #1;
    quiet("reset");
    chk("reset.pix_addr", bus.pix_addr, 25'h0);
    chk("reset.pix_data", bus.pix_data, 16'h0);
    @(negedge byte_clk);
    reset_n = 1'b1;

    // Frame start, two lines, odd word count, address continuation.
    send_pkt(8'h00, 16'd0, 1'b0, -1, -1);
    send_pkt(8'h2A, 16'd8, 1'b0, -1, 8'h10);
    send_pkt(8'h2A, 16'd5, 1'b0, -1, -1);
    send_pkt(8'h2A, 16'd4, 1'b0, -1, -1);
    // Header ECC error, then a normal line.
    send_pkt(8'h2A, 16'd8, 1'b1, -1, -1);
    send_pkt(8'h2A, 16'd6, 1'b0, -1, -1);
    // Truncation after 2 payload cycles and inside the header.
    send_pkt(8'h2A, 16'd8, 1'b0, 4, -1);
    send_pkt(8'h01, 16'd0, 1'b0, 1, -1);
    // Rejected packets, then a frame end.
    send_pkt(8'h6A, 16'd8, 1'b0, -1, -1);
    send_pkt(8'h2B, 16'd8, 1'b0, -1, -1);
    send_pkt(8'h2A, 16'd5000, 1'b0, -1, -1);
    send_pkt(8'h2A, 16'd4097, 1'b0, -1, -1);
    send_pkt(8'h2A, 16'd0, 1'b0, -1, -1);
    send_pkt(8'h01, 16'd0, 1'b0, -1, -1);
    // Largest accepted line.
    send_pkt(8'h2A, 16'd4096, 1'b0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      rdi = dt_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) rdi[7:6] = 2'($urandom_range(1, 3));
      rwc  = 16'($urandom_range(0, 40));
      rcut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : -1;
      send_pkt(rdi, rwc, ($urandom_range(0, 7) == 0), rcut, -1);
    end

    // Reset inside a line; bytes that follow look like a valid FS header
    // but must not be parsed until byte_valid has been low.
    send_pkt(8'h00, 16'd0, 1'b0, -1, -1);
    step(1'b1, 8'h2A, 8'd16);
    step(1'b1, 8'h00, ref_ecc(24'h00102A));
    chk("rst.line_start", bus.line_start, 1'b1);
    step(1'b1, 8'hAA, 8'hBB);
    chk("rst.pix_valid", bus.pix_valid, 2'b11);
    @(negedge byte_clk);
    reset_n        = 1'b0;
    bus.lane0_byte = 8'h00;
    bus.lane1_byte = 8'h00;
    #1;
    exp_addr  = '0;
    exp_lines = '0;
    quiet("rst.async");
    chk("rst.pix_addr", bus.pix_addr, 25'h0);
    chk("rst.pix_data", bus.pix_data, 16'h0);
    @(negedge byte_clk);
    reset_n = 1'b1;
    repeat (4) begin
      step(1'b1, 8'h00, 8'h00);
      quiet("rst.resync");
    end
    step(1'b0, 8'h00, 8'h00);
    quiet("rst.gap");
    send_pkt(8'h2A, 16'd6, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
